// File: rtl/instr_prefetch_unit.sv
`default_nettype none
// ============================================================================
// instr_prefetch_unit : MIPS32 fetch front end with a DEPTH-entry prefetch FIFO
// Revision 1.0
// ============================================================================
module instr_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AW       = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk1,
  input  logic                         rst,
  output logic                         imem_req,
  output logic [AW-1:0]                imem_addr,
  input  logic                         imem_gnt,
  input  logic                         imem_rvalid,
  input  logic [31:0]                  imem_rdata,
  output logic                         if_valid,
  output logic [31:0]                  if_ir,
  output logic [31:0]                  if_npc,
  input  logic                         if_ready,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_pc,
  input  logic                         fetch_halt,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   ir_mem_q  [DEPTH];
  logic [31:0]   npc_mem_q [DEPTH];

  logic issue;
  logic push;
  logic pop;

  // Request is held off during reset so nothing can be granted mid-reset.
  assign imem_req   = (state_q == S_IDLE) & ~fetch_halt & ~redirect & ~rst
                      & (count_q < FULL_C);
  assign imem_addr  = fetch_pc_q[AW-1:0];
  assign issue      = imem_req & imem_gnt;
  assign push       = (state_q == S_WAIT) & imem_rvalid & ~redirect;
  assign if_valid   = (count_q != '0);
  assign pop        = if_valid & if_ready & ~redirect;
  assign if_ir      = if_valid ? ir_mem_q[rd_ptr_q]  : 32'h0000_0000;
  assign if_npc     = if_valid ? npc_mem_q[rd_ptr_q] : 32'h0000_0000;
  assign fifo_count = count_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d    = S_WAIT;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd1;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_IDLE;
        end else if (redirect) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A taken branch overrides everything except reset.
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: reads are masked by the occupancy count.
  always_ff @(posedge clk1) begin
    if (push) begin
      ir_mem_q[wr_ptr_q]  <= imem_rdata;
      npc_mem_q[wr_ptr_q] <= req_pc_q + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_unit.sv
`default_nettype none
// ============================================================================
// tb_instr_prefetch_unit : directed self-checking bench for instr_prefetch_unit
// Revision 1.0
// ============================================================================
module tb_instr_prefetch_unit;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = 32'h0;
  logic        if_valid;
  logic [31:0] if_ir;
  logic [31:0] if_npc;
  logic        if_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_halt;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  int          lat      = 1;
  int          rsp_cnt  = 0;
  logic [31:0] rsp_data = 32'h0;

  instr_prefetch_unit #(
    .DEPTH    (4),
    .AW       (10),
    .RESET_PC (32'h0)
  ) dut (
    .clk1        (clk1),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_ir       (if_ir),
    .if_npc      (if_npc),
    .if_ready    (if_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_halt  (fetch_halt),
    .fifo_count  (fifo_count)
  );

  always #5 clk1 = ~clk1;

  function automatic logic [31:0] mem_word(input int a);
    return 32'h1234_0000 + 32'(a);
  endfunction

  // Memory model: response valid 'lat' cycles after the granting edge.
  always @(posedge clk1) begin
    if (rsp_cnt != 0) rsp_cnt <= rsp_cnt - 1;
    if (imem_req && imem_gnt) begin
      rsp_cnt  <= lat;
      rsp_data <= mem_word(int'(imem_addr));
    end
  end

  always @(negedge clk1) begin
    imem_rvalid = (rsp_cnt == 1);
    imem_rdata  = imem_rvalid ? rsp_data : 32'hDEAD_BEEF;
  end

  task automatic tick();
    @(posedge clk1);
    #2;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    imem_gnt    = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    fetch_halt  = 1'b0;
    if_ready    = 1'b0;
    lat         = 1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    checks++; if (if_ir !== 32'h0) begin errors++; $display("FAIL reset_ir: got %h want 0", if_ir); end
    checks++; if (if_npc !== 32'h0) begin errors++; $display("FAIL reset_npc: got %h want 0", if_npc); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
  endtask

  task automatic test_stream();
    int got;
    do_reset();
    if_ready = 1'b1;
    rst      = 1'b0;
    got      = 0;
    for (int k = 0; k < 40 && got < 4; k++) begin
      if (if_valid) begin
        checks++;
        if (if_ir !== mem_word(got) || if_npc !== 32'(got + 1)) begin
          errors++;
          $display("FAIL stream_%0d: got ir=%h npc=%h want ir=%h npc=%h", got, if_ir, if_npc, mem_word(got), got + 1);
        end
        got++;
      end
      tick();
    end
    checks++; if (got != 4) begin errors++; $display("FAIL stream_timeout: got %0d words want 4", got); end
  endtask

  task automatic test_full_stall();
    int got;
    do_reset();
    rst = 1'b0;
    repeat (20) tick();
    #1;
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", fifo_count); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL full_req: got %b want 0", imem_req); end
    checks++; if (imem_addr !== 10'd4) begin errors++; $display("FAIL full_addr: got %0d want 4", imem_addr); end
    if_ready = 1'b1;
    got      = 0;
    for (int k = 0; k < 40 && got < 5; k++) begin
      if (if_valid) begin
        checks++;
        if (if_ir !== mem_word(got) || if_npc !== 32'(got + 1)) begin
          errors++;
          $display("FAIL drain_%0d: got ir=%h npc=%h want ir=%h npc=%h", got, if_ir, if_npc, mem_word(got), got + 1);
        end
        got++;
      end
      tick();
    end
    checks++; if (got != 5) begin errors++; $display("FAIL drain_timeout: got %0d words want 5", got); end
  endtask

  task automatic test_redirect_wait();
    int k;
    do_reset();
    lat = 3;
    rst = 1'b0;
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h20;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rdw_req_flush: got %b want 0", imem_req); end
    tick();
    redirect = 1'b0;
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rdw_count: got %0d want 0", fifo_count); end
    tick();
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rdw_req_drop: got %b want 0", imem_req); end
    tick();
    #1;
    checks++; if (fifo_count !== 3'd0 || if_valid !== 1'b0) begin errors++; $display("FAIL rdw_discard: got count=%0d valid=%b want 0/0", fifo_count, if_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 10'h20) begin errors++; $display("FAIL rdw_addr: got req=%b addr=%h want 1/020", imem_req, imem_addr); end
    lat      = 1;
    if_ready = 1'b1;
    k = 0;
    while (!if_valid && k < 10) begin tick(); k++; end
    checks++;
    if (if_ir !== mem_word(32'h20) || if_npc !== 32'h21) begin
      errors++; $display("FAIL rdw_first: got ir=%h npc=%h want ir=%h npc=00000021", if_ir, if_npc, mem_word(32'h20));
    end
  endtask

  task automatic test_redirect_rvalid_pop();
    int k;
    do_reset();
    rst = 1'b0;
    k = 0;
    while (fifo_count != 3'd2 && k < 20) begin tick(); k++; end
    tick();
    #1;
    checks++; if (imem_req !== 1'b0 || fifo_count !== 3'd2) begin errors++; $display("FAIL rrp_setup: got req=%b count=%0d want 0/2", imem_req, fifo_count); end
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    if_ready    = 1'b1;
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (fifo_count !== 3'd0 || if_valid !== 1'b0) begin errors++; $display("FAIL rrp_flush: got count=%0d valid=%b want 0/0", fifo_count, if_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 10'h40) begin errors++; $display("FAIL rrp_addr: got req=%b addr=%h want 1/040", imem_req, imem_addr); end
    k = 0;
    while (!if_valid && k < 10) begin tick(); k++; end
    checks++;
    if (if_ir !== mem_word(32'h40) || if_npc !== 32'h41) begin
      errors++; $display("FAIL rrp_first: got ir=%h npc=%h want ir=%h npc=00000041", if_ir, if_npc, mem_word(32'h40));
    end
  endtask

  task automatic test_halt();
    do_reset();
    lat = 2;
    rst = 1'b0;
    tick();
    fetch_halt = 1'b1;
    repeat (2) tick();
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL halt_pushed: got count=%0d want 1", fifo_count); end
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL halt_req_%0d: got %b want 0", i, imem_req); end
      tick();
    end
    checks++; if (if_valid !== 1'b1 || if_ir !== mem_word(0)) begin errors++; $display("FAIL halt_head: got valid=%b ir=%h want 1/%h", if_valid, if_ir, mem_word(0)); end
    if_ready = 1'b1;
    tick();
    checks++;
    if (if_valid !== 1'b0 || if_ir !== 32'h0 || if_npc !== 32'h0) begin
      errors++; $display("FAIL halt_drain: got valid=%b ir=%h npc=%h want 0/0/0", if_valid, if_ir, if_npc);
    end
    fetch_halt = 1'b0;
  endtask

  task automatic test_stale_after_reset();
    int k;
    do_reset();
    rst = 1'b0;
    k = 0;
    while (fifo_count != 3'd3 && k < 30) begin tick(); k++; end
    lat = 2;
    tick();
    #1;
    checks++; if (imem_req !== 1'b0 || fifo_count !== 3'd3) begin errors++; $display("FAIL stale_setup: got req=%b count=%0d want 0/3", imem_req, fifo_count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lat = 1;
    #1;
    checks++; if (fifo_count !== 3'd0 || if_valid !== 1'b0) begin errors++; $display("FAIL stale_rst: got count=%0d valid=%b want 0/0", fifo_count, if_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin errors++; $display("FAIL stale_addr: got req=%b addr=%h want 1/000", imem_req, imem_addr); end
    tick();
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL stale_ignored: got count=%0d want 0", fifo_count); end
    tick();
    checks++;
    if (fifo_count !== 3'd1 || if_ir !== mem_word(0) || if_npc !== 32'h1) begin
      errors++; $display("FAIL stale_first: got count=%0d ir=%h npc=%h want 1/%h/00000001", fifo_count, if_ir, if_npc, mem_word(0));
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full_stall();
    test_redirect_wait();
    test_redirect_rvalid_pop();
    test_halt();
    test_stale_after_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
